// File: rtl/opfetch.sv
// Operand fetch stage: register file, scoreboard and a one-entry operand register for the ALU.
// Latency: 1 cycle from accepted instruction to out_valid; one instruction per cycle when draining.
// Backpressure: in_ready drops while the operand register is held (out_ready low) or a source is pending.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             decoded instruction handshake
//   in_rs1/in_rs2/in_rd           source and destination register indices
//   in_imm/in_use_imm             immediate, selects immediate as y operand
//   out_valid/out_ready           operand handshake towards the ALU
//   out_x/out_y/out_rd            operands and destination index
//   wb_en/wb_rd/wb_data           writeback port from the ALU result path
//
// Optional feature: define OPFETCH_BYPASS_EN to forward a same-cycle writeback
// into a pending source, resolving the hazard without waiting for the register file.
module opfetch #(
    parameter int N = 32,
    parameter int R = 32,
    localparam int IW = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_rs1,
    input  logic [IW-1:0] in_rs2,
    input  logic [IW-1:0] in_rd,
    input  logic [N-1:0]  in_imm,
    input  logic          in_use_imm,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_x,
    output logic [N-1:0]  out_y,
    output logic [IW-1:0] out_rd,
    input  logic          wb_en,
    input  logic [IW-1:0] wb_rd,
    input  logic [N-1:0]  wb_data
);

    logic [N-1:0] rf [R];
    logic [R-1:0] pending;
    logic [R-1:0] pending_nxt;

    logic         pend1, pend2;
    logic         byp1, byp2;
    logic         hazard;
    logic         accept;
    logic [N-1:0] rd1, rd2;
    logic [N-1:0] src1, src2;
    logic         wb_write;

    assign wb_write = wb_en && (wb_rd != '0);

    // Register 0 reads as zero regardless of storage contents.
    assign rd1 = (in_rs1 == '0) ? '0 : rf[in_rs1];
    assign rd2 = (in_rs2 == '0) ? '0 : rf[in_rs2];

    // pending[0] is held at zero, so r0 never creates a hazard.
    assign pend1 = pending[in_rs1];
    assign pend2 = pending[in_rs2] && !in_use_imm;

`ifdef OPFETCH_BYPASS_EN
    assign byp1 = pend1 && wb_write && (wb_rd == in_rs1);
    assign byp2 = pend2 && wb_write && (wb_rd == in_rs2);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign src1 = byp1 ? wb_data : rd1;
    assign src2 = byp2 ? wb_data : rd2;

    assign hazard   = (pend1 && !byp1) || (pend2 && !byp2);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Clear from writeback first, then set from the newly issued producer so
    // that a same-edge set and clear on one index leaves the bit set.
    always_comb begin
        pending_nxt = pending;
        if (wb_en) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (accept && (in_rd != '0)) begin
            pending_nxt[in_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_write) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Operand register: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_rd    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_x     <= src1;
            out_y     <= in_use_imm ? in_imm : src2;
            out_rd    <= in_rd;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/opfetch.md
OPFETCH -- requirements
Module: opfetch

Interface
REQ-001 Parameter: N, default 32, datapath width (register, immediate and operand width).
REQ-002 Parameter: R, default 32, register count; index width is log2(R) (5 at default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 in_valid  in  1  decoded instruction present.
REQ-006 in_ready  out  1  instruction accepted this cycle when high with in_valid.
REQ-007 in_rs1 / in_rs2 / in_rd  in  5 each  source and destination register indices.
REQ-008 in_imm  in  N  immediate operand.
REQ-009 in_use_imm  in  1  y taken from in_imm instead of rs2.
REQ-010 out_valid  out  1  operands held for the ALU.
REQ-011 out_ready  in  1  ALU stage consumes operands.
REQ-012 out_x / out_y  out  N each  operands driving ALU x and y.
REQ-013 out_rd  out  5  destination index travelling with the operands.
REQ-014 wb_en  in  1  writeback strobe from ALU result path.
REQ-015 wb_rd / wb_data  in  5 / N  writeback index and data (ALU z).

Function
REQ-016 Register file: R x N, 2 combinational read ports, 1 write port; write occurs on clk edge when wb_en and wb_rd != 0.
REQ-017 Register 0 always reads 0; writes to it are ignored; it is never pending.
REQ-018 Scoreboard: one pending bit per register; set on accept when in_rd != 0; cleared on wb_en for wb_rd.
REQ-019 Same-edge set and clear on the same index: set wins (newer producer).
REQ-020 Hazard: pending[in_rs1], or pending[in_rs2] with in_use_imm low; hazard not yet resolved by the bypass (REQ-029) blocks acceptance.
REQ-021 in_ready = (!out_valid || out_ready) && !hazard; in_ready depends on no input other than the index, use_imm, out_ready and wb fields.
REQ-022 Accept = in_valid && in_ready; on accept, out_x = rf[rs1], out_y = in_use_imm ? in_imm : rf[rs2], out_rd = in_rd, out_valid = 1 on the next edge (latency 1 cycle).
REQ-023 out_valid && out_ready without accept: out_valid clears; out_x/out_y/out_rd hold their last values.
REQ-024 out_valid && !out_ready: out_x, out_y, out_rd, out_valid held stable.
REQ-025 Simultaneous drain and accept: full throughput, one instruction per cycle.
REQ-026 in_rd equal to in_rs1 or in_rs2: the source reads the pre-issue value.
REQ-027 Writeback to an unpending register: data written, no scoreboard change.

Reset
REQ-028 rst high: immediately clear out_valid, out_x, out_y, out_rd, all pending bits and all registers to 0; in_ready is 1 after release; a transfer in flight is discarded.

Configuration
REQ-029 Macro OPFETCH_BYPASS_EN defined: wb_en with wb_rd matching a pending source (nonzero) clears that hazard the same cycle and wb_data is captured as the operand; without the macro the hazard clears one cycle after writeback and the operand comes from the register file.

Verification
REQ-030 Reset then write r5=0x112233ff, issue rs1=5 rs2=0 -> next cycle out_valid=1, out_x=0x112233ff, out_y=0.
REQ-031 Issue rd=3, then rs1=3 -> in_ready=0 until wb r3=0xffffffff; with macro accepted same cycle, without it one cycle later; out_x=0xffffffff.
REQ-032 out_ready=0 with out_valid=1, new in_valid -> in_ready=0, outputs unchanged over 5 cycles.
REQ-033 Writeback r0=0xdeadbeef, issue rs1=0, in_use_imm=1 imm=1 -> out_x=0, out_y=1, no stall.
REQ-034 Back-to-back 4 independent issues with out_ready=1 -> 4 outputs in 4 consecutive cycles; assert rst mid-stream -> out_valid=0 immediately, pending cleared.
